tdm_demux4: RTL

- Time-division 1-to-4 demultiplexer: the receive end of a 4-slot TDM link.
- On the transmit side, a 4:1 select (s = 00..11 picks i[0]..i[3]) serialises four channels onto one line.
- This block recovers the four channels: it locks to a frame marker, steers each accepted beat to its slot register, and publishes a complete frame atomically.

---
 rtl/tdm_demux4.sv | 100 ++++++++++
 1 files changed

// File: rtl/tdm_demux4.sv
// Receive end of a 4-slot TDM link: locks to a frame marker, steers beats
// into per-slot registers and publishes each complete frame atomically.
module tdm_demux4 #(
    parameter int W = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   din,
    input  logic           din_valid,
    input  logic           frame_sync,
    output logic [4*W-1:0] slot_out,
    output logic [3:0]     slot_wr,
    output logic [4*W-1:0] frame_out,
    output logic           frame_valid,
    output logic           locked,
    output logic           sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t         r_state;
    logic [1:0]     r_cnt;
    logic [W-1:0]   r_slot [4];
    logic [4*W-1:0] r_frame;
    logic [3:0]     r_slot_wr;
    logic           r_frame_valid;
    logic           r_locked;
    logic           r_sync_err;

    // Framing FSM with all outputs registered; pulses default low each cycle
    // and only valid beats move state, so idle cycles simply hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= HUNT;
            r_cnt         <= 2'd0;
            r_slot        <= '{default: '0};
            r_frame       <= '0;
            r_slot_wr     <= 4'b0000;
            r_frame_valid <= 1'b0;
            r_locked      <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_slot_wr     <= 4'b0000;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            if (din_valid) begin
                case (r_state)
                    HUNT: begin
                        if (frame_sync) begin
                            r_slot[0] <= din;
                            r_slot_wr <= 4'b0001;
                            r_cnt     <= 2'd1;
                            r_state   <= LOCKED;
                            r_locked  <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (frame_sync) begin
                            // A marker before slot 3 completes abandons the partial frame.
                            r_sync_err <= (r_cnt != 2'd0);
                            r_slot[0]  <= din;
                            r_slot_wr  <= 4'b0001;
                            r_cnt      <= 2'd1;
                        end else if (r_cnt == 2'd0) begin
                            r_sync_err <= 1'b1;
                            r_cnt      <= 2'd0;
                            r_state    <= HUNT;
                            r_locked   <= 1'b0;
                        end else begin
                            r_slot[r_cnt] <= din;
                            r_slot_wr     <= 4'b0001 << r_cnt;
                            r_cnt         <= r_cnt + 2'd1;
                            if (r_cnt == 2'd3) begin
                                // Slot 3 bypasses its register so the frame lands on the same edge.
                                r_frame       <= {din, r_slot[2], r_slot[1], r_slot[0]};
                                r_frame_valid <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state  <= HUNT;
                        r_locked <= 1'b0;
                        r_cnt    <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign slot_out    = {r_slot[3], r_slot[2], r_slot[1], r_slot[0]};
    assign slot_wr     = r_slot_wr;
    assign frame_out   = r_frame;
    assign frame_valid = r_frame_valid;
    assign locked      = r_locked;
    assign sync_err    = r_sync_err;

endmodule
